// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for a small LEGv8-style datapath.
// Steps each instruction through fetch, decode, execute, memory and
// write-back, with a bounded wait on data memory and a sticky error state.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | stopped at an instruction boundary, waiting for run
// FETCH  | load the instruction register
// DECODE | classify opcode and latch the class
// EXEC   | ALU operation; CBZ/B update the PC and retire here
// MEM    | data-memory access, held until mem_ack or timeout
// WB     | register write-back; PC+4 and retire
// ERR    | illegal opcode or memory timeout; sticky until reset
module multicycle_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        resetl,
   input  logic        run,
   input  logic [10:0] opcode,
   input  logic        zero,
   input  logic        mem_ack,
   output logic        ir_we,
   output logic        pc_we,
   output logic        regwrite,
   output logic        mem_req,
   output logic        mem_we,
   output logic        alusrc,
   output logic        mem2reg,
   output logic        reg2loc,
   output logic        busy,
   output logic        err,
   output logic [1:0]  pc_sel,
   output logic [2:0]  state,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_RSVD   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      C_NONE  = 3'd0,
      C_LDUR  = 3'd1,
      C_STUR  = 3'd2,
      C_RTYPE = 3'd3,
      C_CBZ   = 3'd4,
      C_B     = 3'd5
   } class_t;

   // Last wait count before giving up on mem_ack; the first MEM cycle sees count 0.
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     cur;
   class_t     cls;
   class_t     dec_cls;
   logic [7:0] wait_cnt;
   logic       retire;

   function automatic class_t decode(input logic [10:0] op);
      if (op == 11'h7C2)
         return C_LDUR;
      else if (op == 11'h7C0)
         return C_STUR;
      else if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550)
         return C_RTYPE;
      else if (op[10:3] == 8'hB4)
         return C_CBZ;
      else if (op[10:5] == 6'h05)
         return C_B;
      else
         return C_NONE;
   endfunction

   assign dec_cls = decode(opcode);
   assign state   = cur;

   // An instruction retires in the single cycle where its PC update happens.
   assign retire = (cur == S_EXEC && (cls == C_CBZ || cls == C_B)) ||
                   (cur == S_MEM && cls == C_STUR && mem_ack) ||
                   (cur == S_WB);

   // State, latched class, memory wait counter, retire count and sticky error.
   always_ff @(posedge clk) begin
      if (resetl) begin
         cur      <= S_IDLE;
         cls      <= C_NONE;
         wait_cnt <= '0;
         retired  <= '0;
         err      <= 1'b0;
      end else begin
         if (retire && retired != 32'hFFFF_FFFF)
            retired <= retired + 32'd1;
         case (cur)
            S_IDLE:
               if (run)
                  cur <= S_FETCH;
            S_FETCH:
               cur <= S_DECODE;
            S_DECODE: begin
               cls <= dec_cls;
               if (dec_cls == C_NONE) begin
                  cur <= S_ERR;
                  err <= 1'b1;
               end else begin
                  cur <= S_EXEC;
               end
            end
            S_EXEC:
               case (cls)
                  C_RTYPE: cur <= S_WB;
                  C_LDUR, C_STUR: begin
                     cur      <= S_MEM;
                     wait_cnt <= '0;
                  end
                  C_CBZ, C_B: cur <= run ? S_FETCH : S_IDLE;
                  default: begin
                     cur <= S_ERR;
                     err <= 1'b1;
                  end
               endcase
            S_MEM:
               if (mem_ack) begin
                  if (cls == C_LDUR)
                     cur <= S_WB;
                  else
                     cur <= run ? S_FETCH : S_IDLE;
               end else if (wait_cnt == WAIT_LAST) begin
                  cur <= S_ERR;
                  err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            S_WB:
               cur <= run ? S_FETCH : S_IDLE;
            S_ERR:
               cur <= S_ERR;
            default: begin
               cur <= S_ERR;
               err <= 1'b1;
            end
         endcase
      end
   end

   // Datapath strobes decoded from state and latched class; forced quiet while reset is asserted.
   always_comb begin
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      regwrite = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      alusrc   = 1'b0;
      mem2reg  = 1'b0;
      reg2loc  = 1'b0;
      pc_sel   = 2'd0;
      if (!resetl) begin
         case (cur)
            S_FETCH:
               ir_we = 1'b1;
            S_EXEC: begin
               alusrc  = (cls == C_LDUR) || (cls == C_STUR);
               reg2loc = (cls == C_STUR) || (cls == C_CBZ);
               if (cls == C_CBZ) begin
                  pc_we  = 1'b1;
                  pc_sel = zero ? 2'd1 : 2'd0;
               end else if (cls == C_B) begin
                  pc_we  = 1'b1;
                  pc_sel = 2'd2;
               end
            end
            S_MEM: begin
               mem_req = 1'b1;
               alusrc  = 1'b1;
               mem_we  = (cls == C_STUR);
               pc_we   = (cls == C_STUR) && mem_ack;
            end
            S_WB: begin
               regwrite = 1'b1;
               pc_we    = 1'b1;
               mem2reg  = (cls == C_LDUR);
            end
            default: ;
         endcase
      end
   end

   // busy covers every in-flight state; the reserved encoding counts as error.
   always_comb begin
      busy = (cur != S_IDLE) && (cur != S_ERR) && (cur != S_RSVD);
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: walks each instruction class
// through its state sequence and checks state and strobes every cycle.
module tb_multicycle_sequencer;

   logic        clk = 1'b0;
   logic        resetl = 1'b1;
   logic        run = 1'b0;
   logic [10:0] opcode = '0;
   logic        zero = 1'b0;
   logic        mem_ack = 1'b0;
   logic        ir_we, pc_we, regwrite, mem_req, mem_we, alusrc, mem2reg, reg2loc, busy, err;
   logic [1:0]  pc_sel;
   logic [2:0]  state;
   logic [31:0] retired;
   logic [9:0]  strb;

   int checks = 0;
   int errors = 0;

   // strb bits: ir_we pc_we regwrite mem_req mem_we alusrc mem2reg reg2loc pc_sel[1:0]
   typedef struct packed {
      logic        run;
      logic [10:0] opc;
      logic        zero;
      logic        ack;
      logic [2:0]  st;
      logic [9:0]  sb;
   } vec_t;

   multicycle_sequencer #(.MEM_TIMEOUT(15)) dut (
      .clk(clk), .resetl(resetl), .run(run), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
      .ir_we(ir_we), .pc_we(pc_we), .regwrite(regwrite), .mem_req(mem_req), .mem_we(mem_we),
      .alusrc(alusrc), .mem2reg(mem2reg), .reg2loc(reg2loc), .busy(busy), .err(err),
      .pc_sel(pc_sel), .state(state), .retired(retired)
   );

   assign strb = {ir_we, pc_we, regwrite, mem_req, mem_we, alusrc, mem2reg, reg2loc, pc_sel};

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input vec_t v);
      @(negedge clk);
      run = v.run; opcode = v.opc; zero = v.zero; mem_ack = v.ack;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetl = 1'b1; run = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      resetl = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({state, strb, err, busy} !== {3'd0, 10'h000, 1'b0, 1'b0} || retired !== 32'd0) begin
         errors++;
         $display("FAIL reset_hold: state=%0d strb=%h err=%b busy=%b retired=%0d, expected 0/000/0/0/0",
                  state, strb, err, busy, retired);
      end
      @(negedge clk);
      resetl = 1'b0; run = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({state, strb} !== {3'd0, 10'h000}) begin
         errors++;
         $display("FAIL reset_release: state=%0d strb=%h, expected 0/000", state, strb);
      end
   endtask

   task automatic test_add();
      vec_t tbl [6] = '{
         '{1'b1, 11'h458, 1'b0, 1'b0, 3'd0, 10'h000},
         '{1'b1, 11'h458, 1'b0, 1'b0, 3'd1, 10'h200},
         '{1'b1, 11'h458, 1'b0, 1'b0, 3'd2, 10'h000},
         '{1'b1, 11'h000, 1'b0, 1'b0, 3'd3, 10'h000},
         '{1'b0, 11'h000, 1'b0, 1'b0, 3'd5, 10'h180},
         '{1'b0, 11'h000, 1'b0, 1'b0, 3'd0, 10'h000}};
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i]);
         checks++;
         if ({state, strb} !== {tbl[i].st, tbl[i].sb}) begin
            errors++;
            $display("FAIL add[%0d]: state=%0d strb=%h, expected %0d/%h", i, state, strb, tbl[i].st, tbl[i].sb);
         end
      end
      checks++;
      if (retired !== 32'd1) begin
         errors++;
         $display("FAIL add_retired: got %0d, expected 1", retired);
      end
   endtask

   task automatic test_load();
      vec_t tbl [9] = '{
         '{1'b1, 11'h7C2, 1'b0, 1'b1, 3'd0, 10'h000},
         '{1'b1, 11'h7C2, 1'b0, 1'b1, 3'd1, 10'h200},
         '{1'b1, 11'h7C2, 1'b0, 1'b1, 3'd2, 10'h000},
         '{1'b1, 11'h7C2, 1'b0, 1'b1, 3'd3, 10'h010},
         '{1'b0, 11'h7C2, 1'b0, 1'b0, 3'd4, 10'h050},
         '{1'b0, 11'h7C2, 1'b0, 1'b0, 3'd4, 10'h050},
         '{1'b0, 11'h7C2, 1'b0, 1'b1, 3'd4, 10'h050},
         '{1'b0, 11'h7C2, 1'b0, 1'b0, 3'd5, 10'h188},
         '{1'b0, 11'h7C2, 1'b0, 1'b1, 3'd0, 10'h000}};
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i]);
         checks++;
         if ({state, strb} !== {tbl[i].st, tbl[i].sb}) begin
            errors++;
            $display("FAIL load[%0d]: state=%0d strb=%h, expected %0d/%h", i, state, strb, tbl[i].st, tbl[i].sb);
         end
      end
      checks++;
      if (retired !== 32'd2) begin
         errors++;
         $display("FAIL load_retired: got %0d, expected 2", retired);
      end
   endtask

   task automatic test_back_to_back_branch();
      vec_t tbl [11] = '{
         '{1'b1, 11'h5A0, 1'b0, 1'b0, 3'd0, 10'h000},
         '{1'b1, 11'h5A0, 1'b0, 1'b0, 3'd1, 10'h200},
         '{1'b1, 11'h5A0, 1'b0, 1'b0, 3'd2, 10'h000},
         '{1'b1, 11'h000, 1'b1, 1'b0, 3'd3, 10'h105},
         '{1'b1, 11'h0A0, 1'b1, 1'b0, 3'd1, 10'h200},
         '{1'b1, 11'h0A0, 1'b1, 1'b0, 3'd2, 10'h000},
         '{1'b1, 11'h5A0, 1'b1, 1'b0, 3'd3, 10'h102},
         '{1'b1, 11'h5A0, 1'b0, 1'b0, 3'd1, 10'h200},
         '{1'b1, 11'h5A0, 1'b0, 1'b0, 3'd2, 10'h000},
         '{1'b0, 11'h0A0, 1'b0, 1'b0, 3'd3, 10'h104},
         '{1'b0, 11'h000, 1'b0, 1'b0, 3'd0, 10'h000}};
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i]);
         checks++;
         if ({state, strb} !== {tbl[i].st, tbl[i].sb}) begin
            errors++;
            $display("FAIL branch[%0d]: state=%0d strb=%h, expected %0d/%h", i, state, strb, tbl[i].st, tbl[i].sb);
         end
      end
      checks++;
      if (retired !== 32'd5) begin
         errors++;
         $display("FAIL branch_retired: got %0d, expected 5", retired);
      end
   endtask

   task automatic test_rtype();
      vec_t tbl [14] = '{
         '{1'b1, 11'h658, 1'b0, 1'b0, 3'd0, 10'h000},
         '{1'b1, 11'h658, 1'b0, 1'b0, 3'd1, 10'h200},
         '{1'b1, 11'h658, 1'b0, 1'b0, 3'd2, 10'h000},
         '{1'b1, 11'h658, 1'b0, 1'b0, 3'd3, 10'h000},
         '{1'b1, 11'h450, 1'b0, 1'b0, 3'd5, 10'h180},
         '{1'b1, 11'h450, 1'b0, 1'b0, 3'd1, 10'h200},
         '{1'b1, 11'h450, 1'b0, 1'b0, 3'd2, 10'h000},
         '{1'b1, 11'h450, 1'b0, 1'b0, 3'd3, 10'h000},
         '{1'b1, 11'h550, 1'b0, 1'b0, 3'd5, 10'h180},
         '{1'b1, 11'h550, 1'b0, 1'b0, 3'd1, 10'h200},
         '{1'b1, 11'h550, 1'b0, 1'b0, 3'd2, 10'h000},
         '{1'b1, 11'h550, 1'b0, 1'b0, 3'd3, 10'h000},
         '{1'b0, 11'h550, 1'b0, 1'b0, 3'd5, 10'h180},
         '{1'b0, 11'h000, 1'b0, 1'b0, 3'd0, 10'h000}};
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i]);
         checks++;
         if ({state, strb} !== {tbl[i].st, tbl[i].sb}) begin
            errors++;
            $display("FAIL rtype[%0d]: state=%0d strb=%h, expected %0d/%h", i, state, strb, tbl[i].st, tbl[i].sb);
         end
      end
      checks++;
      if (retired !== 32'd8) begin
         errors++;
         $display("FAIL rtype_retired: got %0d, expected 8", retired);
      end
   endtask

   task automatic test_store();
      vec_t tbl [7] = '{
         '{1'b1, 11'h7C0, 1'b0, 1'b0, 3'd0, 10'h000},
         '{1'b1, 11'h7C0, 1'b0, 1'b0, 3'd1, 10'h200},
         '{1'b1, 11'h7C0, 1'b0, 1'b0, 3'd2, 10'h000},
         '{1'b1, 11'h7C0, 1'b0, 1'b0, 3'd3, 10'h014},
         '{1'b1, 11'h7C0, 1'b0, 1'b0, 3'd4, 10'h070},
         '{1'b0, 11'h7C0, 1'b0, 1'b1, 3'd4, 10'h170},
         '{1'b0, 11'h000, 1'b0, 1'b0, 3'd0, 10'h000}};
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i]);
         checks++;
         if ({state, strb} !== {tbl[i].st, tbl[i].sb}) begin
            errors++;
            $display("FAIL store[%0d]: state=%0d strb=%h, expected %0d/%h", i, state, strb, tbl[i].st, tbl[i].sb);
         end
      end
      checks++;
      if (retired !== 32'd9) begin
         errors++;
         $display("FAIL store_retired: got %0d, expected 9", retired);
      end
   endtask

   task automatic test_reset_mid_mem();
      vec_t tbl [5] = '{
         '{1'b1, 11'h7C2, 1'b0, 1'b0, 3'd0, 10'h000},
         '{1'b1, 11'h7C2, 1'b0, 1'b0, 3'd1, 10'h200},
         '{1'b1, 11'h7C2, 1'b0, 1'b0, 3'd2, 10'h000},
         '{1'b1, 11'h7C2, 1'b0, 1'b0, 3'd3, 10'h010},
         '{1'b1, 11'h7C2, 1'b0, 1'b0, 3'd4, 10'h050}};
      for (int i = 0; i < 5; i++) begin
         drive(tbl[i]);
         checks++;
         if ({state, strb} !== {tbl[i].st, tbl[i].sb}) begin
            errors++;
            $display("FAIL midmem[%0d]: state=%0d strb=%h, expected %0d/%h", i, state, strb, tbl[i].st, tbl[i].sb);
         end
      end
      @(negedge clk);
      resetl = 1'b1;
      #1;
      checks++;
      if (strb !== 10'h000) begin
         errors++;
         $display("FAIL midmem_reset_strobes: strb=%h, expected 000", strb);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({state, strb} !== {3'd0, 10'h000} || retired !== 32'd0) begin
         errors++;
         $display("FAIL midmem_after_reset: state=%0d strb=%h retired=%0d, expected 0/000/0", state, strb, retired);
      end
      @(negedge clk);
      resetl = 1'b0; run = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({state, strb, busy} !== {3'd0, 10'h000, 1'b0}) begin
         errors++;
         $display("FAIL midmem_idle: state=%0d strb=%h busy=%b, expected 0/000/0", state, strb, busy);
      end
   endtask

   task automatic test_timeout();
      vec_t tbl [4] = '{
         '{1'b1, 11'h7C0, 1'b0, 1'b0, 3'd0, 10'h000},
         '{1'b1, 11'h7C0, 1'b0, 1'b0, 3'd1, 10'h200},
         '{1'b1, 11'h7C0, 1'b0, 1'b0, 3'd2, 10'h000},
         '{1'b1, 11'h7C0, 1'b0, 1'b0, 3'd3, 10'h014}};
      vec_t m = '{1'b1, 11'h7C0, 1'b0, 1'b0, 3'd4, 10'h070};
      for (int i = 0; i < 4; i++) begin
         drive(tbl[i]);
         checks++;
         if ({state, strb} !== {tbl[i].st, tbl[i].sb}) begin
            errors++;
            $display("FAIL timeout_pre[%0d]: state=%0d strb=%h, expected %0d/%h", i, state, strb, tbl[i].st, tbl[i].sb);
         end
      end
      for (int i = 0; i < 15; i++) begin
         drive(m);
         checks++;
         if ({state, strb, busy, err} !== {3'd4, 10'h070, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL timeout_mem[%0d]: state=%0d strb=%h busy=%b err=%b, expected 4/070/1/0",
                     i, state, strb, busy, err);
         end
      end
      for (int i = 0; i < 4; i++) begin
         m.run = i[0];
         drive(m);
         checks++;
         if ({state, strb, busy, err} !== {3'd7, 10'h000, 1'b0, 1'b1} || retired !== 32'd0) begin
            errors++;
            $display("FAIL timeout_err[%0d]: state=%0d strb=%h busy=%b err=%b retired=%0d, expected 7/000/0/1/0",
                     i, state, strb, busy, err, retired);
         end
      end
   endtask

   task automatic test_illegal();
      vec_t tbl [6] = '{
         '{1'b1, 11'h000, 1'b0, 1'b0, 3'd0, 10'h000},
         '{1'b1, 11'h000, 1'b0, 1'b0, 3'd1, 10'h200},
         '{1'b1, 11'h000, 1'b0, 1'b0, 3'd2, 10'h000},
         '{1'b0, 11'h000, 1'b0, 1'b0, 3'd7, 10'h000},
         '{1'b1, 11'h458, 1'b0, 1'b1, 3'd7, 10'h000},
         '{1'b0, 11'h458, 1'b0, 1'b0, 3'd7, 10'h000}};
      do_reset();
      @(negedge clk);
      #1;
      checks++;
      if ({state, err} !== {3'd0, 1'b0}) begin
         errors++;
         $display("FAIL err_cleared_by_reset: state=%0d err=%b, expected 0/0", state, err);
      end
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i]);
         checks++;
         if ({state, strb} !== {tbl[i].st, tbl[i].sb}) begin
            errors++;
            $display("FAIL illegal[%0d]: state=%0d strb=%h, expected %0d/%h", i, state, strb, tbl[i].st, tbl[i].sb);
         end
      end
      checks++;
      if ({err, busy} !== 2'b10) begin
         errors++;
         $display("FAIL illegal_err: err=%b busy=%b, expected 1/0", err, busy);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_load();
      test_back_to_back_branch();
      test_rtype();
      test_store();
      test_reset_mid_mem();
      test_timeout();
      test_illegal();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL expose parameter: MEM_TIMEOUT, 15, max cycles mem_req may wait for mem_ack before error (legal 1-255).
REQ-002 SHALL expose port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL expose port: resetl  input  1  reset, synchronous, active-high.
REQ-004 SHALL expose port: run  input  1  level; 1 = execute instructions, 0 = stop at next instruction boundary.
REQ-005 SHALL expose port: opcode  input  11  instruction[31:21] from the instruction register.
REQ-006 SHALL expose port: zero  input  1  ALU zero flag.
REQ-007 SHALL expose port: mem_ack  input  1  data-memory completion, single-cycle pulse or level.
REQ-008 SHALL expose outputs (1 bit each): ir_we, pc_we, regwrite, mem_req, mem_we, alusrc, mem2reg, reg2loc, busy, err.
REQ-009 SHALL expose outputs: pc_sel  2  (0 = PC+4, 1 = PC+branch offset, 2 = PC+uncond offset); state  3  current state encoding; retired  32  retired-instruction count.

Function
REQ-010 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=7; encoding 6 unreachable, treated as ERR next cycle.
REQ-011 SHALL decode in DECODE: LDUR 7C2h, STUR 7C0h, ADD 458h, SUB 658h, AND 450h, ORR 550h, CBZ opcode[10:3]=B4h, B opcode[10:5]=05h; all others -> ERR.
REQ-012 SHALL latch instruction class in DECODE; later states use the latched class, not live opcode.
REQ-013 IDLE: all strobes 0, busy=0; run=1 -> FETCH next cycle.
REQ-014 FETCH: ir_we=1 for exactly one cycle -> DECODE.
REQ-015 DECODE: no strobes; valid class -> EXEC.
REQ-016 EXEC: alusrc=1 for LDUR/STUR, reg2loc=1 for STUR/CBZ; R-type -> WB; LDUR/STUR -> MEM.
REQ-017 EXEC CBZ: pc_we=1, pc_sel=1 if zero else 0; B: pc_we=1, pc_sel=2; both retire and leave to boundary.
REQ-018 MEM: mem_req=1 held every cycle until mem_ack sampled 1; mem_we=1 throughout for STUR, 0 for LDUR; alusrc stays 1.
REQ-019 MEM on ack: LDUR -> WB; STUR: pc_we=1, pc_sel=0, retire, boundary.
REQ-020 MEM timeout: 8-bit wait counter cleared on MEM entry, increments each non-ack cycle; at count = MEM_TIMEOUT without ack -> ERR, no retire.
REQ-021 mem_ack outside MEM SHALL be ignored.
REQ-022 WB: regwrite=1 one cycle, mem2reg=1 only for LDUR, pc_we=1, pc_sel=0, retire, boundary.
REQ-023 Boundary: next state FETCH if run=1 else IDLE, evaluated in the retiring cycle.
REQ-024 pc_we SHALL be 1 in exactly one cycle per retired instruction; regwrite never in the same cycle as mem_req.
REQ-025 retired SHALL increment by 1 in each retiring cycle, saturating at FFFF_FFFFh.
REQ-026 ERR: all strobes 0, err=1 and busy=0, sticky until reset; run ignored.
REQ-027 busy=1 in every state except IDLE and ERR.
REQ-028 Outputs other than state, retired, err, busy SHALL be combinational from state and latched class; pc_sel=0 whenever pc_we=0.

Reset
REQ-029 resetl=1 at a clock edge SHALL force state=IDLE, retired=0, err=0, wait counter=0, latched class cleared, regardless of current state, including mid-MEM.
REQ-030 During and after reset, all strobes SHALL be 0 until run=1 is sampled with resetl=0.

Verification
REQ-031 ADD (458h), run=1 -> IDLE,FETCH,DECODE,EXEC,WB; regwrite=1, pc_we=1 in WB only; retired 0->1; 5 cycles IDLE to retire.
REQ-032 LDUR (7C2h), mem_ack after 3 MEM cycles -> mem_req high 3 cycles, mem_we=0, then WB with mem2reg=1, regwrite=1.
REQ-033 STUR (7C0h), no mem_ack, MEM_TIMEOUT=15 -> 15 MEM cycles then ERR, err=1, retired unchanged, mem_req=0 in ERR.
REQ-034 CBZ (5A0h) with zero=1 -> EXEC pc_we=1, pc_sel=1; zero=0 -> pc_sel=0; B (0A0h) -> pc_sel=2.
REQ-035 run dropped during LDUR MEM -> instruction completes, WB then IDLE; resetl=1 mid-MEM -> IDLE next cycle, mem_req=0, retired=0.
REQ-036 Opcode 000h in DECODE -> ERR; run toggling afterward leaves state=7 until resetl.
